// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and the Galois LFSR step used by the instruction/data memory responders.
package inst_mem_responder_pkg;

  // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int          LATENCY_MAX       = 8;

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Pipelined cyc/stb/stall/ack instruction-fetch bus; the master drives requests, the slave returns words.
interface inst_mem_responder_if;
  logic        inst_cyc_in;
  logic        inst_stb_in;
  logic [31:0] inst_addr_in;
  logic        inst_stall_out;
  logic        inst_ack_out;
  logic [31:0] inst_data_out;

  modport master (
    output inst_cyc_in, inst_stb_in, inst_addr_in,
    input  inst_stall_out, inst_ack_out, inst_data_out
  );

  modport slave (
    input  inst_cyc_in, inst_stb_in, inst_addr_in,
    output inst_stall_out, inst_ack_out, inst_data_out
  );
endinterface

// File: rtl/inst_mem_responder_lfsr16.sv
// Seedable 16-bit Galois LFSR: advances one step per enabled cycle, reloads the seed on synchronous reset.
module lfsr16
  import inst_mem_responder_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsrNext(state);
    end
  end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction RAM slave: one word per accepted request, acked in order exactly LATENCY cycles after acceptance.
// Acks cannot be refused, so the read pipeline never stalls; only request acceptance is throttled via stall.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int          AW           = 10,
  parameter int          LATENCY      = 2,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] LFSR_SEED    = LFSR_DEFAULT_SEED,
  parameter int          STALL_THRESH = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  inst_mem_responder_if.slave    inst,
  input  logic                   load_we_in,
  input  logic [AW-1:0]          load_addr_in,
  input  logic [31:0]            load_data_in
);

  localparam int DEPTH = 1 << AW;

  logic [15:0] lfsr;
  logic        stallInject;
  logic        accept;
  logic [AW-1:0] rdIdx;
  logic [31:0] rdWord;
  logic [31:0] mem [DEPTH];

  logic [LATENCY-1:0] pipeVld;
  logic [31:0]        pipeDat [LATENCY];

  logic unusedBits;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) uLfsr (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .en    (1'b1),
    .state (lfsr)
  );

  // Stall depends only on registered state, never on stb, so the master sees it before deciding to strobe.
  assign stallInject         = STALL_EN && ({13'd0, lfsr[2:0]} < 16'(STALL_THRESH));
  assign inst.inst_stall_out = sys_rst | stallInject;

  assign accept = inst.inst_cyc_in & inst.inst_stb_in & ~inst.inst_stall_out & ~sys_rst;

  // Byte offset and bits above the RAM index are dropped: misaligned fetches and aliases hit the same word.
  assign rdIdx  = inst.inst_addr_in[AW+1:2];
  assign rdWord = mem[rdIdx];

  always_ff @(posedge sys_clk) begin
    if (load_we_in) begin
      mem[load_addr_in] <= load_data_in;
    end
  end

  // Dropping cyc abandons everything in flight, matching the master forgetting its outstanding fetches.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !inst.inst_cyc_in) begin
      pipeVld <= '0;
    end else begin
      pipeVld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        pipeVld[i] <= pipeVld[i-1];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      pipeDat[0] <= rdWord;
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipeDat[i] <= pipeDat[i-1];
    end
  end

  assign inst.inst_ack_out  = pipeVld[LATENCY-1];
  assign inst.inst_data_out = pipeVld[LATENCY-1] ? pipeDat[LATENCY-1] : 32'h0;

  assign unusedBits = ^{inst.inst_addr_in[31:AW+2], inst.inst_addr_in[1:0], lfsr[15:3]};

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench: three responders (default, stall injection, single-cycle latency) on one clock and preload port.
module tb_inst_mem_responder;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        load_we_in;
  logic [9:0]  load_addr_in;
  logic [31:0] load_data_in;

  int errors = 0;
  int checks = 0;

  logic [31:0] wordA [4];
  logic [15:0] refLfsr;
  logic        refStall;

  int          dueQ [$];
  logic [31:0] datQ [$];
  int          accCnt;
  int          ackCnt;
  int          ai;
  logic        accNow;

  always #5 sys_clk = ~sys_clk;

  inst_mem_responder_if bus0 ();
  inst_mem_responder_if bus1 ();
  inst_mem_responder_if bus2 ();

  assign bus2.inst_cyc_in  = bus0.inst_cyc_in;
  assign bus2.inst_stb_in  = bus0.inst_stb_in;
  assign bus2.inst_addr_in = bus0.inst_addr_in;

  inst_mem_responder uDut0 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .inst         (bus0),
    .load_we_in   (load_we_in),
    .load_addr_in (load_addr_in),
    .load_data_in (load_data_in)
  );

  inst_mem_responder #(.STALL_EN(1'b1), .STALL_THRESH(4)) uDut1 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .inst         (bus1),
    .load_we_in   (load_we_in),
    .load_addr_in (load_addr_in),
    .load_data_in (load_data_in)
  );

  inst_mem_responder #(.LATENCY(1)) uDut2 (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .inst         (bus2),
    .load_we_in   (load_we_in),
    .load_addr_in (load_addr_in),
    .load_data_in (load_data_in)
  );

  // Reference Galois LFSR, taps 16,14,13,11, seed 16'hACE1.
  function automatic logic [15:0] refNext(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'b1011_0100_0000_0000;
    return n;
  endfunction

  always @(posedge sys_clk) refLfsr <= sys_rst ? 16'hACE1 : refNext(refLfsr);
  assign refStall = sys_rst | (refLfsr[2:0] < 3'd4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wordA[0] = 32'h1111_0000;
    wordA[1] = 32'h2222_0001;
    wordA[2] = 32'h3333_0002;
    wordA[3] = 32'h4444_0003;

    sys_rst = 1'b1;
    load_we_in = 1'b0; load_addr_in = '0; load_data_in = '0;
    bus0.inst_cyc_in = 1'b0; bus0.inst_stb_in = 1'b0; bus0.inst_addr_in = '0;
    bus1.inst_cyc_in = 1'b0; bus1.inst_stb_in = 1'b0; bus1.inst_addr_in = '0;
    step(); step();

    chk("rst_stall0", 32'(bus0.inst_stall_out), 32'd1);
    chk("rst_stall1", 32'(bus1.inst_stall_out), 32'd1);
    chk("rst_ack0",   32'(bus0.inst_ack_out),   32'd0);
    chk("rst_data0",  bus0.inst_data_out,       32'h0);

    // Preload while still in reset.
    load_we_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_addr_in = 10'(i); load_data_in = wordA[i];
      step();
    end
    load_addr_in = 10'd5; load_data_in = 32'h0050_0093;
    step();
    load_we_in = 1'b0;
    chk("rst_stall0_hold", 32'(bus0.inst_stall_out), 32'd1);

    sys_rst = 1'b0;
    step();
    chk("run_stall0", 32'(bus0.inst_stall_out), 32'd0);
    chk("run_stall1", 32'(bus1.inst_stall_out), 32'(refStall));

    // Single fetch of RAM[5] via byte address 0x14.
    bus0.inst_cyc_in = 1'b1; bus0.inst_stb_in = 1'b1; bus0.inst_addr_in = 32'h14;
    step();
    bus0.inst_stb_in = 1'b0;
    chk("single_ack_early", 32'(bus0.inst_ack_out), 32'd0);
    chk("lat1_ack",         32'(bus2.inst_ack_out), 32'd1);
    chk("lat1_data",        bus2.inst_data_out,     32'h0050_0093);
    step();
    chk("single_ack",      32'(bus0.inst_ack_out), 32'd1);
    chk("single_data",     bus0.inst_data_out,     32'h0050_0093);
    chk("lat1_ack_after",  32'(bus2.inst_ack_out), 32'd0);
    step();
    chk("single_ack_late",  32'(bus0.inst_ack_out), 32'd0);
    chk("single_data_late", bus0.inst_data_out,     32'h0);

    // Streaming: four back-to-back accepts give four back-to-back acks.
    for (int k = 0; k < 6; k++) begin
      bus0.inst_stb_in  = (k < 4);
      bus0.inst_addr_in = 32'(k * 4);
      if (k < 4) chk("stream_stall", 32'(bus0.inst_stall_out), 32'd0);
      step();
      chk("stream_ack", 32'(bus0.inst_ack_out), (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      chk("stream_data", bus0.inst_data_out, (k >= 1 && k <= 4) ? wordA[k-1] : 32'h0);
    end

    // Cycle abort: the first request completes before cyc drops; the second is discarded.
    bus0.inst_stb_in = 1'b1; bus0.inst_addr_in = 32'h0;
    step();
    chk("abort_ack_e1", 32'(bus0.inst_ack_out), 32'd0);
    bus0.inst_addr_in = 32'h4;
    step();
    chk("abort_ack_first",  32'(bus0.inst_ack_out), 32'd1);
    chk("abort_data_first", bus0.inst_data_out,     wordA[0]);
    bus0.inst_cyc_in = 1'b0; bus0.inst_stb_in = 1'b0;
    step();
    chk("abort_ack_drop",  32'(bus0.inst_ack_out), 32'd0);
    chk("abort_data_drop", bus0.inst_data_out,     32'h0);
    step();
    chk("abort_ack_none", 32'(bus0.inst_ack_out), 32'd0);
    bus0.inst_cyc_in = 1'b1; bus0.inst_stb_in = 1'b1; bus0.inst_addr_in = 32'h8;
    step();
    bus0.inst_stb_in = 1'b0;
    step();
    chk("abort_resume_ack",  32'(bus0.inst_ack_out), 32'd1);
    chk("abort_resume_data", bus0.inst_data_out,     wordA[2]);

    // Reset while a request is in flight.
    bus0.inst_stb_in = 1'b1; bus0.inst_addr_in = 32'h14;
    step();
    bus0.inst_stb_in = 1'b0;
    sys_rst = 1'b1;
    step();
    chk("midrst_stall0", 32'(bus0.inst_stall_out), 32'd1);
    chk("midrst_stall1", 32'(bus1.inst_stall_out), 32'd1);
    chk("midrst_ack",    32'(bus0.inst_ack_out),   32'd0);
    chk("midrst_data",   bus0.inst_data_out,       32'h0);
    step();
    chk("midrst_ack2", 32'(bus0.inst_ack_out), 32'd0);
    sys_rst = 1'b0;
    step();
    chk("postrst_ack",    32'(bus0.inst_ack_out),   32'd0);
    chk("postrst_data",   bus0.inst_data_out,       32'h0);
    chk("postrst_stall1", 32'(bus1.inst_stall_out), 32'(refStall));
    step();
    chk("postrst_ack2", 32'(bus0.inst_ack_out), 32'd0);

    // Aliased, misaligned fetch of RAM[5] colliding with a preload of the same word.
    bus0.inst_stb_in = 1'b1; bus0.inst_addr_in = 32'h1016;
    load_we_in = 1'b1; load_addr_in = 10'd5; load_data_in = 32'hDEAD_BEEF;
    step();
    bus0.inst_stb_in = 1'b0; load_we_in = 1'b0;
    step();
    chk("alias_ack",      32'(bus0.inst_ack_out), 32'd1);
    chk("alias_old_data", bus0.inst_data_out,     32'h0050_0093);
    bus0.inst_stb_in = 1'b1;
    step();
    bus0.inst_stb_in = 1'b0;
    step();
    chk("alias_new_data", bus0.inst_data_out, 32'hDEAD_BEEF);

    // Stall injection: requests held until accepted; acks must track the reference stall pattern.
    accCnt = 0; ackCnt = 0; ai = 0;
    bus1.inst_cyc_in = 1'b1; bus1.inst_stb_in = 1'b1; bus1.inst_addr_in = 32'h0;
    for (int c = 0; c < 203; c++) begin
      if (c == 200) bus1.inst_stb_in = 1'b0;
      accNow = 1'b0;
      if (c < 200) begin
        chk("inj_stall", 32'(bus1.inst_stall_out), 32'(refStall));
        if (!refStall) begin
          accNow = 1'b1;
          dueQ.push_back(c + 1);
          datQ.push_back(wordA[ai]);
          accCnt++;
        end
      end
      step();
      if (accNow) begin
        ai = (ai + 1) % 4;
        bus1.inst_addr_in = 32'(ai * 4);
      end
      if (bus1.inst_ack_out === 1'b1) ackCnt++;
      if (dueQ.size() > 0 && dueQ[0] == c) begin
        chk("inj_ack",  32'(bus1.inst_ack_out), 32'd1);
        chk("inj_data", bus1.inst_data_out,     datQ[0]);
        void'(dueQ.pop_front());
        void'(datQ.pop_front());
      end else begin
        chk("inj_ack_idle",  32'(bus1.inst_ack_out), 32'd0);
        chk("inj_data_idle", bus1.inst_data_out,     32'h0);
      end
    end
    chk("inj_ack_count", 32'(ackCnt), 32'(accCnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
